data_size_selector: RTL and testbench



---
 rtl/data_size_selector.sv | 86 ++++++++
 tb/tb_data_size_selector.sv | 138 +++++++++++++
 2 files changed

// File: rtl/data_size_selector.sv
// Registered memory-access size decoder for the ARM datapath.
// The size comes from a forced DSS mode, or from the load/store encoding in IR.
module data_size_selector (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [31:0] IR,
  input  logic [1:0]  DSS,
  output logic [1:0]  DataSize,
  output logic        SignExt,
  output logic        Illegal
);

  logic [1:0] size_d, size_q;
  logic       sext_d, sext_q;
  logic       ill_d,  ill_q;
  logic       extra_ls_s;
  logic       load_s;

  assign extra_ls_s = (IR[27:25] == 3'b000) && IR[7] && IR[4] && (IR[6:5] != 2'b00);
  assign load_s     = IR[20];

  // Combinational decode of the next size/sign/illegal values
  always_comb begin
    size_d = 2'b10;
    sext_d = 1'b0;
    ill_d  = 1'b0;
    case (DSS)
      2'b00: size_d = 2'b10;
      2'b10: size_d = 2'b00;
      2'b11: size_d = 2'b11;
      2'b01: begin
        if (IR[27:26] == 2'b01) begin
          size_d = IR[22] ? 2'b00 : 2'b10;
        end else if (extra_ls_s) begin
          // SH=1x with L=0 is the dual-register form (LDRD/STRD)
          case (IR[6:5])
            2'b01: size_d = 2'b01;
            2'b10: begin
              if (load_s) begin
                size_d = 2'b00;
                sext_d = 1'b1;
              end else begin
                size_d = 2'b11;
                sext_d = 1'b0;
              end
            end
            2'b11: begin
              if (load_s) begin
                size_d = 2'b01;
                sext_d = 1'b1;
              end else begin
                size_d = 2'b11;
                sext_d = 1'b0;
              end
            end
            default: size_d = 2'b10;
          endcase
        end else if (IR[27:25] == 3'b100) begin
          size_d = 2'b10;
        end else begin
          ill_d = 1'b1;
        end
      end
      default: size_d = 2'b10;
    endcase
  end

  // Output registers with async reset to word access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q <= 2'b10;
      sext_q <= 1'b0;
      ill_q  <= 1'b0;
    end else if (en) begin
      size_q <= size_d;
      sext_q <= sext_d;
      ill_q  <= ill_d;
    end
  end

  assign DataSize = size_q;
  assign SignExt  = sext_q;
  assign Illegal  = ill_q;

endmodule

// File: tb/tb_data_size_selector.sv
// Scoreboard bench for data_size_selector: a reference model pushes expected
// outputs at each clock edge and a negedge monitor pops and compares.
module tb_data_size_selector;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [31:0] IR;
  logic [1:0]  DSS;
  logic [1:0]  DataSize;
  logic        SignExt;
  logic        Illegal;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [3:0] exp_q[$];
  logic [3:0] model_st;

  data_size_selector dut (
    .clk(clk), .reset_n(reset_n), .en(en), .IR(IR), .DSS(DSS),
    .DataSize(DataSize), .SignExt(SignExt), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: classify the instruction, then look up {size, sext, illegal}
  function automatic logic [3:0] ref_decode(input logic [31:0] ir, input logic [1:0] dss);
    int unsigned op3, op2, sh;
    bit is_load, is_byte;
    op2 = (ir >> 26) & 32'd3;
    op3 = (ir >> 25) & 32'd7;
    sh  = (ir >> 5) & 32'd3;
    is_load = ((ir >> 20) & 32'd1) != 0;
    is_byte = ((ir >> 22) & 32'd1) != 0;
    if (dss == 2'd0) return 4'b1000;
    if (dss == 2'd2) return 4'b0000;
    if (dss == 2'd3) return 4'b1100;
    if (op2 == 1) return is_byte ? 4'b0000 : 4'b1000;
    if (op3 == 0 && ir[7] && ir[4] && sh != 0) begin
      if (sh == 1) return 4'b0100;
      if (!is_load) return 4'b1100;
      if (sh == 2) return 4'b0010;
      return 4'b0110;
    end
    if (op3 == 4) return 4'b1000;
    return 4'b1001;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got size=%b sext=%b ill=%b, expected size=%b sext=%b ill=%b",
                  name, act[3:2], act[1], act[0], exp[3:2], exp[1], exp[0]);
  endtask

  // Model: predict the registered state at every rising edge
  always @(posedge clk) begin
    if (!reset_n) model_st = 4'b1000;
    else if (en) model_st = ref_decode(IR, DSS);
    exp_q.push_back(model_st);
  end

  // Monitor: pop one expectation per cycle and compare with the DUT
  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", {DataSize, SignExt, 1'b0} | {3'b000, Illegal}, e);
    end
  end

  task automatic cyc(input logic e, input logic [31:0] ir, input logic [1:0] dss);
    @(posedge clk);
    #1;
    en  = e;
    IR  = ir;
    DSS = dss;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: r[27:26] = 2'b01;
      1: begin r[27:25] = 3'b000; r[7] = 1'b1; r[4] = 1'b1; end
      2: r[27:25] = 3'b100;
      default: r = r;
    endcase
    return r;
  endfunction

  initial begin
    reset_n = 1'b0;
    en  = 1'b0;
    IR  = 32'h0000_0000;
    DSS = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    cyc(1'b1, 32'hE1E65BDE, 2'b01);
    cyc(1'b1, 32'hE1E65BDE, 2'b00);
    cyc(1'b1, 32'hE1E65BDE, 2'b10);
    cyc(1'b1, 32'hE1E65BDE, 2'b11);
    cyc(1'b1, 32'hE5565014, 2'b01);
    cyc(1'b1, 32'hE5165014, 2'b01);
    cyc(1'b1, 32'hE1D650B4, 2'b01);
    cyc(1'b1, 32'hE1D650D4, 2'b01);
    cyc(1'b1, 32'hE1D650F4, 2'b01);
    cyc(1'b1, 32'hE8BD000F, 2'b01);
    cyc(1'b1, 32'hE0810002, 2'b01);
    cyc(1'b1, 32'hE0810002, 2'b10);
    repeat (3) cyc(1'b0, 32'hE0810002, 2'b11);
    cyc(1'b1, 32'hE0810002, 2'b11);
    cyc(1'b1, 32'hE0810002, 2'b11);

    // DataSize is now 11; assert reset between edges and look immediately
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check("async_reset", {DataSize, SignExt, Illegal}, 4'b1000);
    cyc(1'b1, 32'hE1D650F4, 2'b01);
    reset_n = 1'b1;
    cyc(1'b1, 32'hE1D650D4, 2'b01);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), rand_ir(), 2'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    #1;
    chk_cnt++;
    if (exp_q.size() <= 1) pass_cnt++;
    else $display("FAIL queue_drain: %0d entries left, expected at most 1", exp_q.size());
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
